// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM inputs and MEM/WB outputs of the MIPS memory stage
interface mem_stage_if;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [31:0] add_result;
    logic        zero;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        mem_fault;
    logic [1:0]  wb_ctl;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic [31:0] wb_data;

    modport master (
        output wb_ctlout, m_ctlout, alu_result, rdata2out, add_result, zero, five_bit_muxout,
        input  pcsrc, branch_target, mem_fault, wb_ctl, read_data, mem_alu_result,
               mem_write_reg, wb_data
    );

    modport slave (
        input  wb_ctlout, m_ctlout, alu_result, rdata2out, add_result, zero, five_bit_muxout,
        output pcsrc, branch_target, mem_fault, wb_ctl, read_data, mem_alu_result,
               mem_write_reg, wb_data
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: word data memory, branch resolve, MEM/WB register
module mem_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] index;
    logic          misaligned;
    logic          do_read;
    logic          do_write;

    logic [1:0]    wb_ctl_q;
    logic [31:0]   read_data_q;
    logic [31:0]   alu_q;
    logic [4:0]    write_reg_q;
    logic          fault_q;

    // Upper address bits are dropped, so accesses wrap modulo DEPTH*4 bytes.
    assign index      = bus.alu_result[AW+1:2];
    assign misaligned = (bus.alu_result[1:0] != 2'b00) && (bus.m_ctlout[1] || bus.m_ctlout[0]);
    assign do_read    = bus.m_ctlout[1] && !misaligned;
    assign do_write   = bus.m_ctlout[0] && !misaligned;

    assign bus.pcsrc         = bus.m_ctlout[2] & bus.zero;
    assign bus.branch_target = bus.add_result;

    // A store seen while reset is held belongs to a killed instruction.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[index] <= bus.rdata2out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_ctl_q    <= '0;
            read_data_q <= '0;
            alu_q       <= '0;
            write_reg_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            wb_ctl_q    <= bus.wb_ctlout;
            read_data_q <= do_read ? mem[index] : 32'h0;
            alu_q       <= bus.alu_result;
            write_reg_q <= bus.five_bit_muxout;
            if (misaligned) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign bus.wb_ctl         = wb_ctl_q;
    assign bus.read_data      = read_data_q;
    assign bus.mem_alu_result = alu_q;
    assign bus.mem_write_reg  = write_reg_q;
    assign bus.mem_fault      = fault_q;
    assign bus.wb_data        = wb_ctl_q[0] ? read_data_q : alu_q;
endmodule
